// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides.
// Single-cycle ops land in HOLD at the edge they are accepted. MUL runs a
// WIDTH-step shift-add multiply and loads the product on the final step.
// Result and flags are registered and held until the consumer takes them.
module alu_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             parity,
  output logic             overflow,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_reg;

  // Registered result and flags
  logic [WIDTH-1:0] out_reg;
  logic             zero_reg, carry_reg, sign_reg, parity_reg, overflow_reg;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [2*WIDTH-1:0] acc_next;

  // Single-cycle ALU intermediates (one extra bit catches carry/borrow/shift-out)
  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum_ext, diff_ext, shl_ext, shr_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;

  // Load path into the output registers
  logic             accept, start_mul, start_alu, mul_last, load_en;
  logic [WIDTH-1:0] res_next;
  logic             carry_next, ovf_next;

  assign in_ready  = (state_reg == IDLE) | ((state_reg == HOLD) & out_ready);
  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg == MUL);

  assign accept    = in_valid & in_ready;
  assign start_mul = accept & (select == OP_MUL);
  assign start_alu = accept & (select != OP_MUL);
  assign mul_last  = (state_reg == MUL) & (cnt_reg == SHW'(WIDTH - 1));
  assign load_en   = start_alu | mul_last;

  assign shamt    = b[SHW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  // Shifting through an extra bit leaves the last bit shifted out there (0 for amount 0)
  assign shl_ext  = {1'b0, a} << shamt;
  assign shr_ext  = {a, 1'b0} >> shamt;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // Single-cycle operation result, carry and overflow
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (select)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res   = shl_ext[WIDTH-1:0];
        alu_carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_ext[WIDTH:1];
        alu_carry = shr_ext[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Pick what gets loaded into out/flags: finished product or ALU result
  always_comb begin
    res_next   = alu_res;
    carry_next = alu_carry;
    ovf_next   = alu_ovf;
    if (mul_last) begin
      res_next   = acc_next[WIDTH-1:0];
      carry_next = |acc_next[2*WIDTH-1:WIDTH];
      ovf_next   = 1'b0;
    end
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_mul)      state_reg <= MUL;
          else if (start_alu) state_reg <= HOLD;
        end
        MUL: begin
          if (mul_last) state_reg <= HOLD;
        end
        HOLD: begin
          if (start_mul)      state_reg <= MUL;
          else if (start_alu) state_reg <= HOLD;
          else if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Shift-add multiplier: latch operands on accept, one step per MUL cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (start_mul) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == MUL) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + SHW'(1);
    end
  end

  // Output registers: only written on a load, so they hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg      <= '0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      sign_reg     <= 1'b0;
      parity_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (load_en) begin
      out_reg      <= res_next;
      zero_reg     <= (res_next == '0);
      carry_reg    <= carry_next;
      sign_reg     <= res_next[WIDTH-1];
      parity_reg   <= ^res_next;
      overflow_reg <= ovf_next;
    end
  end

  assign out      = out_reg;
  assign zero     = zero_reg;
  assign carry    = carry_reg;
  assign sign     = sign_reg;
  assign parity   = parity_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8). Expected results are
// pushed when an operation is accepted and popped when the DUT hands it over.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, c, s, p, o;
  } exp_t;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, out;
  logic [2:0]   select;
  logic         zero, carry, sign, parity, overflow, busy;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out;
  logic [4:0]   prev_flags;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .carry(carry), .sign(sign),
    .parity(parity), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour written from the operation definitions
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] prod;
    int s;
    e = '0;
    s = int'(y) % W;
    case (op)
      OP_ADD: begin
        e.res = x + y;
        e.c   = (int'(x) + int'(y)) > 255;
        e.o   = ($signed(x) + $signed(y) > 127) || ($signed(x) + $signed(y) < -128);
      end
      OP_SUB: begin
        e.res = x - y;
        e.c   = x < y;
        e.o   = ($signed(x) - $signed(y) > 127) || ($signed(x) - $signed(y) < -128);
      end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_SHL: begin
        e.res = x << s;
        e.c   = (s == 0) ? 1'b0 : x[W-s];
      end
      OP_SHR: begin
        e.res = x >> s;
        e.c   = (s == 0) ? 1'b0 : x[s-1];
      end
      default: begin
        prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res = prod[W-1:0];
        e.c   = (prod[2*W-1:W] != 0);
      end
    endcase
    e.z = (e.res == 0);
    e.s = e.res[W-1];
    e.p = ^e.res;
    return e;
  endfunction

  // Monitor: sample just before each rising edge, where the handshake is decided
  always @(negedge clk) begin
    #4;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out", 32'(out), 32'(prev_out));
        check("stall_flags", 32'({zero, carry, sign, parity, overflow}), 32'(prev_flags));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          txn++;
          $display("txn %0d: out=%02h z=%b c=%b s=%b p=%b o=%b (exp %02h %b%b%b%b%b)",
                   txn, out, zero, carry, sign, parity, overflow,
                   mon_e.res, mon_e.z, mon_e.c, mon_e.s, mon_e.p, mon_e.o);
          check("out", 32'(out), 32'(mon_e.res));
          check("zero", 32'(zero), 32'(mon_e.z));
          check("carry", 32'(carry), 32'(mon_e.c));
          check("sign", 32'(sign), 32'(mon_e.s));
          check("parity", 32'(parity), 32'(mon_e.p));
          check("overflow", 32'(overflow), 32'(mon_e.o));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_flags = {zero, carry, sign, parity, overflow};
    end
  end

  // Present one operation at a negedge; return at the negedge after it is accepted
  task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int  n;
    logic ok;
    select   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      #4;
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(model(op, x, y));
      end
      @(negedge clk);
      if (!ok) begin
        out_ready = 1'b1;
        n++;
      end
    end
    in_valid = 1'b0;
    // operands are don't-care while not presented
    a      = W'($urandom);
    b      = W'($urandom);
    select = 3'($urandom);
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Let every outstanding result drain; ends at a negedge with the block idle
  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_flags"}, 32'({zero, carry, sign, parity, overflow}), 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    select    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed single-cycle ops
    send(OP_ADD, 8'h7F, 8'h01);
    check("add_latency", 32'(out_valid), 32'd1);
    check("add_out_direct", 32'(out), 32'h80);
    send(OP_SUB, 8'h05, 8'h07);
    send(OP_AND, 8'hF0, 8'h0F);
    send(OP_OR,  8'hA0, 8'h05);
    send(OP_XOR, 8'hFF, 8'h0F);
    send(OP_SHL, 8'h81, 8'h09);
    send(OP_SHR, 8'h81, 8'h01);
    send(OP_SHL, 8'h5A, 8'h08);
    send(OP_SHR, 8'hA5, 8'h00);
    send(OP_SHR, 8'h80, 8'h07);
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_SUB, 8'h80, 8'h01);
    drain();

    // Multiply: busy and stalled input for exactly W cycles
    send(OP_MUL, 8'h0F, 8'h0D);
    n = 0;
    while (!out_valid && n < 40) begin
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    check("mul_latency", 32'(n), 32'(W));
    drain();
    send(OP_MUL, 8'h12, 8'h10);
    drain();

    // Backpressure: result held for 5 cycles, then a back-to-back accept
    out_ready = 1'b0;
    send(OP_ADD, 8'h3C, 8'h4D);
    repeat (5) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(OP_ADD, 8'h11, 8'h22);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_out_direct", 32'(out), 32'h33);
    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(0, 6)), W'($urandom), W'($urandom));
      check("b2b_no_bubble", 32'(out_valid), 32'd1);
    end
    // mul straight from HOLD
    send(OP_MUL, 8'hFF, 8'hFF);
    check("hold_to_mul_busy", 32'(busy), 32'd1);
    drain();

    // Random mix with random backpressure
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      send(op, W'($urandom), W'($urandom));
    end
    drain();

    // Reset three cycles into a multiply discards it
    send(OP_MUL, 8'h0F, 8'h0D);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check_idle("mul_reset");
    send(OP_ADD, 8'h01, 8'h02);
    check("post_reset_valid", 32'(out_valid), 32'd1);
    drain();

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered ALU with valid/ready handshake on both sides. It is the sequential successor of the team's 4-bit combinational ALU. It extends the op set to 8 operations, including a multi-cycle shift-add multiply, and registers every result and flag. It sits between an operand producer, such as a register-file read stage, and a result consumer that can stall.

Parameters:
WIDTH, 8, operand/result width; must be a power of 2, >= 4
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
select  input  3  operation code
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
out  output  WIDTH  result
zero, carry, sign, parity, overflow  output  1 each  registered flags, aligned with out
busy  output  1  high while in MUL state

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst. On rst: state=IDLE; out, all flags, out_valid and busy = 0; any multiply in flight is discarded. rst overrides every other input.
- Accept = in_valid & in_ready, sampled at the rising edge.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is a combinational path from out_ready; in_ready=0 in MUL.
- Ops:
  - 000 add: out=a+b, carry=carry-out, overflow=signed overflow.
  - 001 sub: out=a-b, carry=borrow (a<b unsigned), overflow=signed overflow.
  - 010 and; 011 or; 100 xor.
  - 101 shl: out=a<<b[SHW-1:0].
  - 110 shr: logical, out=a>>b[SHW-1:0].
  - 111 mul: out=low WIDTH bits of unsigned a*b.
- Shift flags: carry=last bit shifted out; if shift amount is 0, carry=0. Upper bits of b above SHW-1 are ignored.
- Mul flags: carry = OR of the high WIDTH product bits.
- overflow=0 for all ops except add/sub. carry=0 for the logic ops.
- Common flags for every op: zero=(out==0); sign=out[WIDTH-1]; parity=^out (1 = odd number of ones).
- States:
  - IDLE: out_valid=0. Single-cycle op accepted -> result and flags registered at that edge, go to HOLD. Mul accepted -> latch a, b, clear 2*WIDTH accumulator and counter, go to MUL.
  - MUL: one shift-add step per cycle; busy=1. After WIDTH steps, load out/flags and go to HOLD.
  - HOLD: out_valid=1; out and flags stay stable until out_ready=1.
    - out_ready=1 with no accept -> IDLE.
    - out_ready=1 with a simultaneous accept -> behave as IDLE-accept. A single-cycle op stays in HOLD with the new result (back-to-back, no bubble). A mul moves to MUL with out_valid=0.
- Latency: single-cycle ops have out_valid high the cycle after accept. Mul has out_valid high WIDTH cycles after accept.
- Throughput:
  - Single-cycle ops: 1 per cycle under continuous out_ready.
  - Mul: 1 per WIDTH+1 cycles. The block returns to HOLD/IDLE before the next accept; a back-to-back accept from HOLD is allowed.
- Inputs a/b/select are ignored while not accepted. in_valid may drop without penalty; the producer must hold values stable only until accept.
- Flags and out never change while out_valid=1 and out_ready=0.

Test Plan:
- WIDTH=8, add a=0x7F b=0x01, out_ready=1 -> next cycle out_valid=1, out=0x80, carry=0, overflow=1, sign=1, parity=1, zero=0.
- sub a=0x05 b=0x07 -> out=0xFE, carry=1, overflow=0, sign=1, parity=1. Then and a=0xF0 b=0x0F -> out=0x00, zero=1, carry=0.
- shl a=0x81 b=0x09 (amount 1) -> out=0x02, carry=1. shr a=0x81 b=0x01 -> out=0x40, carry=1. shl by 0 -> out=a, carry=0.
- mul a=0x0F b=0x0D -> in_ready=0 and busy=1 for 8 cycles; out_valid rises 8 cycles after accept; out=0xC3, carry=0, sign=1, parity=0. mul a=0x12 b=0x10 -> out=0x20, carry=1.
- Backpressure: add result with out_ready=0 for 5 cycles -> out/flags stable, in_ready=0. Then out_ready=1 with a new add presented -> new result the next cycle, no bubble.
- Assert rst 3 cycles into a mul -> next cycle state=IDLE, out_valid=0, busy=0, out=0, in_ready=1. A following add completes correctly.
